// File: rtl/paddle_pkg.sv
// Shared definitions for the multi-paddle mover: direction bit positions inside a
// 4-button group, the per-direction FSM encoding and the axis clamp helper.
package paddle_pkg;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } dirState_e;

  // The sum is formed in 32-bit signed arithmetic, so a step past a bound saturates instead of wrapping.
  function automatic int clampAxis(input int value, input int delta, input int lo, input int hi);
    int sum;
    sum = value + delta;
    if (sum < lo) begin
      return lo;
    end else if (sum > hi) begin
      return hi;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// One active-low button: 2-flop synchroniser, counting debouncer and hold/auto-repeat
// FSM. `step` is a 1-cycle pulse, combinational on the registered state.
module button_conditioner
  import paddle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 250
) (
  input  logic clock,
  input  logic reset,
  input  logic buttonRaw,
  output logic step
);

  localparam int DCW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MAX_TIME = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW       = $clog2(MAX_TIME + 1);

  logic [1:0]     syncQ_r;
  logic           debLevel_r;
  logic [DCW-1:0] debCount_r;
  dirState_e      state_r, stateNext_s;
  logic [TW-1:0]  timer_r, timerNext_s;
  logic           pressed_s;

  assign pressed_s = ~debLevel_r;

  // Synchroniser and debouncer; the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      syncQ_r    <= 2'b11;
      debLevel_r <= 1'b1;
      debCount_r <= '0;
    end else begin
      syncQ_r <= {syncQ_r[0], buttonRaw};
      if (syncQ_r[1] == debLevel_r) begin
        debCount_r <= '0;
      end else if (debCount_r == DCW'(DEBOUNCE_CYCLES - 1)) begin
        debLevel_r <= ~debLevel_r;
        debCount_r <= '0;
      end else begin
        debCount_r <= debCount_r + DCW'(1);
      end
    end
  end

  // FSM state and timer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      timer_r <= '0;
    end else begin
      state_r <= stateNext_s;
      timer_r <= timerNext_s;
    end
  end

  // Hold/repeat next-state and step pulse; release always wins over a due step.
  always_comb begin
    stateNext_s = state_r;
    timerNext_s = timer_r;
    step        = 1'b0;
    case (state_r)
      IDLE: begin
        if (pressed_s) begin
          step        = 1'b1;
          stateNext_s = HOLD;
          timerNext_s = '0;
        end else begin
          timerNext_s = '0;
        end
      end
      HOLD: begin
        if (!pressed_s) begin
          stateNext_s = IDLE;
          timerNext_s = '0;
        end else if (timer_r == TW'(HOLD_CYCLES - 1)) begin
          step        = 1'b1;
          stateNext_s = REPEAT;
          timerNext_s = '0;
        end else begin
          timerNext_s = timer_r + TW'(1);
        end
      end
      REPEAT: begin
        if (!pressed_s) begin
          stateNext_s = IDLE;
          timerNext_s = '0;
        end else if (timer_r == TW'(REPEAT_CYCLES - 1)) begin
          step        = 1'b1;
          timerNext_s = '0;
        end else begin
          timerNext_s = timer_r + TW'(1);
        end
      end
      default: begin
        stateNext_s = IDLE;
        timerNext_s = '0;
      end
    endcase
  end

endmodule

// File: rtl/multi_paddle_mover.sv
// N independent paddles: conditions every button bit, then combines steps per axis,
// clamps, and applies recenter/freeze before registering positions and the moved strobe.
module multi_paddle_mover
  import paddle_pkg::*;
#(
  parameter int N_PADDLES       = 2,
  parameter int X_W             = 8,
  parameter int Y_W             = 9,
  parameter int X_INIT          = 115,
  parameter int Y_INIT          = 240,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 235,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479,
  parameter int STEP            = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 250
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [4*N_PADDLES-1:0]   button,
  input  logic                     freeze,
  input  logic [N_PADDLES-1:0]     recenter,
  output logic [X_W*N_PADDLES-1:0] paddleXValue,
  output logic [Y_W*N_PADDLES-1:0] paddleYValue,
  output logic [N_PADDLES-1:0]     moved
);

  logic [4*N_PADDLES-1:0] stepPulse_s;

  for (genvar b = 0; b < 4 * N_PADDLES; b++) begin : gCond
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) uCond (
      .clock    (clock),
      .reset    (reset),
      .buttonRaw(button[b]),
      .step     (stepPulse_s[b])
    );
  end

  for (genvar p = 0; p < N_PADDLES; p++) begin : gPaddle
    logic [X_W-1:0] xPos_r, xNext_s;
    logic [Y_W-1:0] yPos_r, yNext_s;
    logic           moved_r;
    int             dx_s, dy_s;

    // Opposing steps in the same cycle cancel because both deltas are summed.
    always_comb begin
      dx_s    = (stepPulse_s[4*p+DIR_RIGHT] ? STEP : 0) - (stepPulse_s[4*p+DIR_LEFT] ? STEP : 0);
      dy_s    = (stepPulse_s[4*p+DIR_DOWN]  ? STEP : 0) - (stepPulse_s[4*p+DIR_UP]   ? STEP : 0);
      xNext_s = X_W'(clampAxis(int'(xPos_r), dx_s, X_MIN, X_MAX));
      yNext_s = Y_W'(clampAxis(int'(yPos_r), dy_s, Y_MIN, Y_MAX));
    end

    // Position register: reset > recenter > freeze > step.
    always_ff @(posedge clock) begin
      if (reset) begin
        xPos_r  <= X_W'(X_INIT);
        yPos_r  <= Y_W'(Y_INIT);
        moved_r <= 1'b0;
      end else if (recenter[p]) begin
        xPos_r  <= X_W'(X_INIT);
        yPos_r  <= Y_W'(Y_INIT);
        moved_r <= (xPos_r != X_W'(X_INIT)) || (yPos_r != Y_W'(Y_INIT));
      end else if (freeze) begin
        moved_r <= 1'b0;
      end else begin
        xPos_r  <= xNext_s;
        yPos_r  <= yNext_s;
        moved_r <= (xNext_s != xPos_r) || (yNext_s != yPos_r);
      end
    end

    assign paddleXValue[X_W*p +: X_W] = xPos_r;
    assign paddleYValue[Y_W*p +: Y_W] = yPos_r;
    assign moved[p]                   = moved_r;
  end

endmodule

// File: tb/tb_multi_paddle_mover.sv
// Directed bench: default-parameter instance plus a STEP=50 instance for the clamp cases.
module tb_multi_paddle_mover;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  button, button2;
  logic        freeze;
  logic [1:0]  recenter, recenter2;
  logic [15:0] xv, xv2;
  logic [17:0] yv, yv2;
  logic [1:0]  moved, moved2;

  int checks   = 0;
  int failures = 0;
  int c0, c1, d0, d1;
  int a0, a1, b0, b1;
  int pulseAt[4];
  int nPulse;
  int expX[4] = '{165, 215, 235, 235};
  int expXP[4] = '{1, 1, 1, 0};
  int expY[6] = '{190, 140, 90, 40, 0, 0};
  int expYP[6] = '{1, 1, 1, 1, 1, 0};

  always #5 clock = ~clock;

  multi_paddle_mover dut (
    .clock(clock), .reset(reset), .button(button), .freeze(freeze), .recenter(recenter),
    .paddleXValue(xv), .paddleYValue(yv), .moved(moved)
  );

  multi_paddle_mover #(.STEP(50)) dut2 (
    .clock(clock), .reset(reset), .button(button2), .freeze(1'b0), .recenter(recenter2),
    .paddleXValue(xv2), .paddleYValue(yv2), .moved(moved2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int xOf(input int p);
    return int'(xv[p*8 +: 8]);
  endfunction

  function automatic int yOf(input int p);
    return int'(yv[p*9 +: 9]);
  endfunction

  task automatic runCount(input int n, output int m0, output int m1, output int n0, output int n1);
    m0 = 0; m1 = 0; n0 = 0; n1 = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      m0 += int'(moved[0]);
      m1 += int'(moved[1]);
      n0 += int'(moved2[0]);
      n1 += int'(moved2[1]);
    end
  endtask

  initial begin
    reset = 1'b1; button = 8'hFF; button2 = 8'hFF; freeze = 1'b0;
    recenter = 2'b00; recenter2 = 2'b00;
    repeat (3) tick();
    check("rst_x0", xOf(0), 115);
    check("rst_y1", yOf(1), 240);
    check("rst_moved", int'(moved), 0);
    reset = 1'b0;
    runCount(20, c0, c1, d0, d1);
    check("idle_x0", xOf(0), 115);
    check("idle_x1", xOf(1), 115);
    check("idle_y0", yOf(0), 240);
    check("idle_y1", yOf(1), 240);
    check("idle_pulses", c0 + c1, 0);

    // Single press of paddle 0 up: update lands on the 7th edge.
    button[3] = 1'b0;
    repeat (6) tick();
    check("up_pre_moved", int'(moved[0]), 0);
    check("up_pre_y0", yOf(0), 240);
    tick();
    check("up_moved", int'(moved[0]), 1);
    check("up_y0", yOf(0), 239);
    check("up_y1", yOf(1), 240);
    repeat (3) tick();
    button[3] = 1'b1;
    runCount(20, c0, c1, d0, d1);
    check("up_after_pulses", c0 + c1, 0);
    check("up_final_y0", yOf(0), 239);

    button[2] = 1'b0;
    runCount(10, c0, c1, d0, d1);
    button[2] = 1'b1;
    runCount(20, a0, a1, b0, b1);
    check("down_pulses", c0 + a0, 1);
    check("down_y0", yOf(0), 240);

    // Paddle 1 left held through hold and one repeat; released before the second repeat.
    nPulse = 0;
    pulseAt = '{0, 0, 0, 0};
    button[5] = 1'b0;
    for (int i = 1; i <= 1400; i++) begin
      tick();
      if (moved[1]) begin
        if (nPulse < 4) pulseAt[nPulse] = i;
        nPulse++;
      end
      if (i == 1375) button[5] = 1'b1;
    end
    check("rep_count", nPulse, 3);
    check("rep_t0", pulseAt[0], 7);
    check("rep_t1", pulseAt[1], 1007);
    check("rep_t2", pulseAt[2], 1257);
    check("rep_x1", xOf(1), 112);
    check("rep_x0", xOf(0), 115);

    // Bouncing right button never survives debounce.
    c0 = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) button[0] = ~button[0];
      tick();
      c0 += int'(moved[0]);
    end
    button[0] = 1'b1;
    runCount(20, a0, a1, b0, b1);
    check("bounce_pulses", c0 + a0, 0);
    check("bounce_x0", xOf(0), 115);

    button[3:2] = 2'b00;
    runCount(10, c0, c1, d0, d1);
    button[3:2] = 2'b11;
    runCount(20, a0, a1, b0, b1);
    check("updown_pulses", c0 + a0, 0);
    check("updown_y0", yOf(0), 240);

    // Freeze: the step is issued while frozen and is lost.
    freeze = 1'b1;
    button[0] = 1'b0;
    runCount(10, c0, c1, d0, d1);
    button[0] = 1'b1;
    runCount(20, a0, a1, b0, b1);
    freeze = 1'b0;
    runCount(10, b0, b1, d0, d1);
    check("freeze_pulses", c0 + a0 + b0, 0);
    check("freeze_x0", xOf(0), 115);

    // Recenter coinciding with a right step.
    button[3] = 1'b0;
    runCount(10, c0, c1, d0, d1);
    button[3] = 1'b1;
    runCount(20, c0, c1, d0, d1);
    check("pre_rc_y0", yOf(0), 239);
    button[0] = 1'b0;
    repeat (6) tick();
    recenter[0] = 1'b1;
    tick();
    recenter[0] = 1'b0;
    check("rc_x0", xOf(0), 115);
    check("rc_y0", yOf(0), 240);
    check("rc_moved", int'(moved[0]), 1);
    runCount(3, c0, c1, d0, d1);
    button[0] = 1'b1;
    runCount(20, a0, a1, b0, b1);
    check("rc_after_pulses", c0 + a0, 0);
    check("rc_after_x0", xOf(0), 115);

    // Reset during REPEAT with the button still held.
    button[4] = 1'b0;
    runCount(1100, c0, c1, d0, d1);
    check("hold_pulses", c1, 2);
    check("hold_x1", xOf(1), 114);
    reset = 1'b1;
    repeat (2) tick();
    check("midrst_x1", xOf(1), 115);
    check("midrst_moved", int'(moved), 0);
    reset = 1'b0;
    repeat (6) tick();
    check("fresh_pre_x1", xOf(1), 115);
    check("fresh_pre_moved", int'(moved[1]), 0);
    tick();
    check("fresh_x1", xOf(1), 116);
    check("fresh_moved", int'(moved[1]), 1);
    button[4] = 1'b1;
    runCount(20, c0, c1, d0, d1);
    check("fresh_after_pulses", c1, 0);

    // STEP=50 instance: clamp at X_MAX and at Y_MIN without wrap.
    for (int k = 0; k < 4; k++) begin
      button2[0] = 1'b0;
      runCount(10, c0, c1, d0, d1);
      button2[0] = 1'b1;
      runCount(20, a0, a1, b0, b1);
      check($sformatf("clampx%0d_x", k), int'(xv2[7:0]), expX[k]);
      check($sformatf("clampx%0d_pulses", k), d0 + b0, expXP[k]);
    end
    for (int k = 0; k < 6; k++) begin
      button2[3] = 1'b0;
      runCount(10, c0, c1, d0, d1);
      button2[3] = 1'b1;
      runCount(20, a0, a1, b0, b1);
      check($sformatf("clampy%0d_y", k), int'(yv2[8:0]), expY[k]);
      check($sformatf("clampy%0d_pulses", k), d0 + b0, expYP[k]);
    end
    check("clamp_other_paddle", int'(xv2[15:8]), 115);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
